// File: rtl/calipso_rom_pkg.sv
// Shared definitions for the ROM download sequencer: region map,
// download size and the sequencer state enumeration.
package calipso_rom_pkg;

  // Region map of the download image (byte addresses).
  localparam int unsigned CPU_BASE = 32'h0000_0000;
  localparam int unsigned CPU_SIZE = 32'h0000_6000;
  localparam int unsigned SND_BASE = 32'h0000_6000;
  localparam int unsigned SND_SIZE = 32'h0000_2000;
  localparam int unsigned GFX_BASE = 32'h0000_8000;
  localparam int unsigned GFX_SIZE = 32'h0000_2000;

  // A valid download covers every byte of the three regions.
  localparam int unsigned TOTAL_BYTES_DEF = GFX_BASE + GFX_SIZE;

  // One-hot region select bit positions.
  localparam int REGION_CPU = 0;
  localparam int REGION_SND = 1;
  localparam int REGION_GFX = 2;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } load_state_e;

endpackage

// File: rtl/rom_load_seq_if.sv
// HPS download bus as seen by the ROM sequencer.
//
// Protocol: ioctl_download is a level that frames a whole download.
// ioctl_wr is a one-cycle strobe with no back-pressure (there is no
// ready): every cycle with ioctl_wr high carries one byte, ioctl_dout,
// for byte address ioctl_addr, and the receiver must take it that cycle.
interface rom_load_seq_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout
  );
endinterface

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte address into a one-hot ROM
// region select and the byte offset inside that region.
module rom_region_decode
  import calipso_rom_pkg::*;
(
  rom_load_seq_if.slave bus,
  output logic [2:0]    sel,
  output logic [14:0]   offset
);

  logic [31:0] addr;

  assign addr = 32'(bus.ioctl_addr);

  // Ordered range compare; addresses beyond the graphics region select nothing.
  always_comb begin
    sel    = 3'b000;
    offset = '0;
    if (addr < SND_BASE) begin
      sel[REGION_CPU] = 1'b1;
      offset          = 15'(addr - CPU_BASE);
    end else if (addr < GFX_BASE) begin
      sel[REGION_SND] = 1'b1;
      offset          = 15'(addr - SND_BASE);
    end else if (addr < GFX_BASE + GFX_SIZE) begin
      sel[REGION_GFX] = 1'b1;
      offset          = 15'(addr - GFX_BASE);
    end
  end

endmodule

// File: rtl/rom_load_seq.sv
// ROM download sequencer: routes HPS download bytes into the CPU, sound
// and graphics ROMs, validates the byte count and holds the game core in
// reset until a complete image has been loaded and has settled.
module rom_load_seq
  import calipso_rom_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TOTAL_BYTES   = TOTAL_BYTES_DEF
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  output logic        cpu_rom_we,
  output logic        snd_rom_we,
  output logic        gfx_rom_we,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count,
  output load_state_e fsm_state
);

  rom_load_seq_if bus ();

  assign bus.ioctl_download = ioctl_download;
  assign bus.ioctl_wr       = ioctl_wr;
  assign bus.ioctl_addr     = ioctl_addr;
  assign bus.ioctl_dout     = ioctl_dout;

  logic [2:0]  sel;
  logic [14:0] offset;

  rom_region_decode u_decode (
    .bus    (bus),
    .sel    (sel),
    .offset (offset)
  );

  load_state_e state, state_nxt;
  logic [15:0] settle_cnt, settle_nxt;
  logic        dl_prev;
  logic        dl_rise, dl_fall;
  logic        accept, load_good, settle_done;
  logic [16:0] count_inc, count_after;

  assign dl_rise = bus.ioctl_download & ~dl_prev;
  assign dl_fall = ~bus.ioctl_download & dl_prev;

  // Only in-range bytes of an active download are written and counted.
  assign accept = (state == ST_LOAD) && bus.ioctl_wr &&
                  (32'(bus.ioctl_addr) < TOTAL_BYTES) && (sel != 3'b000);

  assign count_inc   = (byte_count == 17'h1FFFF) ? byte_count : byte_count + 17'd1;
  // A byte arriving in the same cycle the download ends still counts.
  assign count_after = accept ? count_inc : byte_count;
  assign load_good   = (32'(count_after) == TOTAL_BYTES);
  assign settle_done = (32'(settle_cnt) + 32'd1 >= SETTLE_CYCLES);

  assign core_reset = (state != ST_RUN);
  assign fsm_state  = state;

  // State register and settle counter.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= ST_EMPTY;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next state: a new download pre-empts everything else.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    if (dl_rise) begin
      state_nxt  = ST_LOAD;
      settle_nxt = '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (dl_fall) begin
            state_nxt  = load_good ? ST_SETTLE : ST_FAIL;
            settle_nxt = '0;
          end
        end
        ST_SETTLE: begin
          if (rst_req) begin
            settle_nxt = '0;
          end else if (settle_done) begin
            state_nxt  = ST_RUN;
            settle_nxt = '0;
          end else begin
            settle_nxt = settle_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          if (rst_req) begin
            state_nxt  = ST_SETTLE;
            settle_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered ROM write port, byte counter and load verdict.
  always_ff @(posedge clk) begin
    if (RESET) begin
      dl_prev    <= 1'b0;
      cpu_rom_we <= 1'b0;
      snd_rom_we <= 1'b0;
      gfx_rom_we <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      byte_count <= '0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      dl_prev    <= bus.ioctl_download;
      cpu_rom_we <= accept & sel[REGION_CPU];
      snd_rom_we <= accept & sel[REGION_SND];
      gfx_rom_we <= accept & sel[REGION_GFX];
      if (accept) begin
        rom_addr <= offset;
        rom_data <= bus.ioctl_dout;
      end
      if (dl_rise) begin
        byte_count <= '0;
        load_ok    <= 1'b0;
        load_err   <= 1'b0;
      end else begin
        byte_count <= count_after;
        if ((state == ST_LOAD) && dl_fall) begin
          load_ok  <= load_good;
          load_err <= ~load_good;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_load_seq.sv
// Bench for rom_load_seq: directed phases with random data and addresses,
// a region model computed from the address map, and a strobe scoreboard.
module tb_rom_load_seq;
  import calipso_rom_pkg::*;

  localparam int TOTAL  = 40960;
  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rst_req;
  logic        cpu_rom_we, snd_rom_we, gfx_rom_we;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset, load_ok, load_err;
  logic [16:0] byte_count;
  load_state_e fsm_state;

  rom_load_seq_if bus ();

  rom_load_seq #(
    .SETTLE_CYCLES (SETTLE),
    .TOTAL_BYTES   (TOTAL)
  ) dut (
    .clk            (clk),
    .RESET          (reset),
    .ioctl_download (bus.ioctl_download),
    .ioctl_wr       (bus.ioctl_wr),
    .ioctl_addr     (bus.ioctl_addr),
    .ioctl_dout     (bus.ioctl_dout),
    .rst_req        (rst_req),
    .cpu_rom_we     (cpu_rom_we),
    .snd_rom_we     (snd_rom_we),
    .gfx_rom_we     (gfx_rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .core_reset     (core_reset),
    .load_ok        (load_ok),
    .load_err       (load_err),
    .byte_count     (byte_count),
    .fsm_state      (fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {gfx,snd,cpu strobes, region offset, data}.
  logic [25:0] exp_q[$];
  bit          model_loading = 0;
  int          model_count   = 0;
  int          cnt_cpu = 0, cnt_snd = 0, cnt_gfx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: region and local offset from the memory map arithmetic.
  function automatic logic [25:0] model_entry(input logic [24:0] a, input logic [7:0] d);
    int unsigned ai;
    ai = int'(a);
    if (ai < 24576)      return {3'b001, 15'(ai), d};
    else if (ai < 32768) return {3'b010, 15'(ai - 24576), d};
    else                 return {3'b100, 15'(ai - 32768), d};
  endfunction

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [2:0]  we;
    logic [25:0] got, want;
    we = {gfx_rom_we, snd_rom_we, cpu_rom_we};
    if (we != 3'b000) begin
      cnt_cpu += int'(cpu_rom_we);
      cnt_snd += int'(snd_rom_we);
      cnt_gfx += int'(gfx_rom_we);
      got  = {we, rom_addr, rom_data};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 26'd0;
      chk("strobe", 32'(got), 32'(want));
    end
  end

  // Watchdog.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_write(input logic [24:0] a, input logic [7:0] d, input bit fall_now);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (fall_now) bus.ioctl_download = 1'b0;
    if (model_loading && (int'(a) < TOTAL)) begin
      exp_q.push_back(model_entry(a, d));
      if (model_count < 17'h1FFFF) model_count++;
    end
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
    if (fall_now) model_loading = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_download();
    bus.ioctl_download = 1'b1;
    @(posedge clk); #1;
    model_loading = 1;
    model_count   = 0;
  endtask

  task automatic end_download();
    bus.ioctl_download = 1'b0;
    @(posedge clk); #1;
    model_loading = 0;
  endtask

  // Edges until core_reset is seen low, bounded.
  task automatic wait_core_low(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n, b_cpu, b_snd, b_gfx;
    reset = 1'b1;
    rst_req = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    idle(3);

    // Reset state.
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_strobes", 32'({gfx_rom_we, snd_rom_we, cpu_rom_we}), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_data", 32'(rom_data), 0);
    chk("rst_ok_err", 32'({load_ok, load_err}), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_state", 32'(fsm_state), 32'(ST_EMPTY));
    reset = 1'b0;
    idle(1);

    // Writes without a download are ignored.
    for (int i = 0; i < 5; i++) drive_write(25'($urandom_range(32'h9FFF, 0)), 8'($urandom), 0);
    idle(1);
    chk("empty_ignore_count", 32'(byte_count), 0);
    chk("empty_state", 32'(fsm_state), 32'(ST_EMPTY));

    // Full load with out-of-range bytes; last byte lands with the falling edge.
    b_cpu = cnt_cpu; b_snd = cnt_snd; b_gfx = cnt_gfx;
    start_download();
    chk("load_state", 32'(fsm_state), 32'(ST_LOAD));
    for (int a = 0; a < TOTAL - 1; a++) drive_write(25'(a), 8'($urandom), 0);
    for (int i = 0; i < 100; i++)
      drive_write(25'($urandom_range(32'h1FFFFFF, 32'hA000)), 8'($urandom), 0);
    drive_write(25'(TOTAL - 1), 8'($urandom), 1);
    chk("full_byte_count", 32'(byte_count), 32'(model_count));
    chk("full_load_ok", 32'(load_ok), 32'(model_count == TOTAL));
    chk("full_load_err", 32'(load_err), 32'(model_count != TOTAL));
    chk("full_settle_state", 32'(fsm_state), 32'(ST_SETTLE));
    wait_core_low(n);
    chk("full_settle_cycles", 32'(n), 32'(SETTLE));
    chk("full_cpu_strobes", 32'(cnt_cpu - b_cpu), 24576);
    chk("full_snd_strobes", 32'(cnt_snd - b_snd), 8192);
    chk("full_gfx_strobes", 32'(cnt_gfx - b_gfx), 8192);
    chk("full_q_empty", 32'(exp_q.size()), 0);
    chk("run_state", 32'(fsm_state), 32'(ST_RUN));

    // Reset request in RUN for three cycles.
    rst_req = 1'b1;
    idle(1);
    chk("rstreq_core_reset", 32'(core_reset), 1);
    idle(2);
    rst_req = 1'b0;
    wait_core_low(n);
    chk("rstreq_settle_cycles", 32'(n), 32'(SETTLE));

    // Region boundaries, then random addresses with gaps; ends short.
    start_download();
    chk("reload_core_reset", 32'(core_reset), 1);
    chk("reload_ok_cleared", 32'({load_ok, byte_count}), 0);
    drive_write(25'h6000, 8'h5A, 0);
    chk("b6000_strobes", 32'({gfx_rom_we, snd_rom_we, cpu_rom_we}), 32'b010);
    chk("b6000_addr", 32'(rom_addr), 0);
    chk("b6000_data", 32'(rom_data), 32'h5A);
    drive_write(25'h5FFF, 8'($urandom), 0);
    chk("b5fff_strobes", 32'({gfx_rom_we, snd_rom_we, cpu_rom_we}), 32'b001);
    chk("b5fff_addr", 32'(rom_addr), 32'h5FFF);
    drive_write(25'h8000, 8'($urandom), 0);
    chk("b8000_gfx", 32'({gfx_rom_we, rom_addr}), {16'd0, 1'b1, 15'd0});
    drive_write(25'hA000, 8'($urandom), 0);
    chk("ba000_none", 32'({gfx_rom_we, snd_rom_we, cpu_rom_we}), 0);
    for (int i = 0; i < 200; i++) begin
      drive_write(25'($urandom_range(32'hA0FF, 0)), 8'($urandom), 0);
      if ($urandom_range(2, 0) == 0) idle($urandom_range(2, 1));
    end
    end_download();
    chk("rand_byte_count", 32'(byte_count), 32'(model_count));
    chk("rand_load_err", 32'(load_err), 32'(model_count != TOTAL));
    chk("rand_state", 32'(fsm_state), 32'(ST_FAIL));
    rst_req = 1'b1;
    idle(2);
    rst_req = 1'b0;
    idle(1);
    chk("fail_rstreq_state", 32'(fsm_state), 32'(ST_FAIL));

    // Short load: one byte missing.
    start_download();
    for (int a = 0; a < TOTAL - 1; a++) drive_write(25'(a), 8'($urandom), 0);
    end_download();
    chk("short_byte_count", 32'(byte_count), 40959);
    chk("short_load_err", 32'({load_ok, load_err}), 32'b01);
    idle(20);
    chk("short_core_reset", 32'(core_reset), 1);
    chk("short_state", 32'(fsm_state), 32'(ST_FAIL));
    chk("short_q_empty", 32'(exp_q.size()), 0);

    // RESET part way through a download.
    start_download();
    for (int a = 0; a < 1000; a++) drive_write(25'(a), 8'($urandom), 0);
    reset = 1'b1;
    model_loading = 0;
    @(posedge clk); #1;
    bus.ioctl_download = 1'b0;
    idle(1);
    reset = 1'b0;
    chk("mid_q_empty", 32'(exp_q.size()), 0);
    chk("mid_core_reset", 32'(core_reset), 1);
    chk("mid_rom_port", 32'({gfx_rom_we, snd_rom_we, cpu_rom_we, rom_addr, rom_data}), 0);
    chk("mid_ok_err_count", 32'({load_ok, load_err, byte_count}), 0);
    chk("mid_state", 32'(fsm_state), 32'(ST_EMPTY));
    b_cpu = cnt_cpu; b_snd = cnt_snd; b_gfx = cnt_gfx;
    for (int i = 0; i < 10; i++) drive_write(25'($urandom_range(32'h9FFF, 0)), 8'($urandom), 0);
    idle(2);
    chk("mid_ignore_strobes", 32'((cnt_cpu - b_cpu) + (cnt_snd - b_snd) + (cnt_gfx - b_gfx)), 0);
    chk("mid_ignore_count", 32'(byte_count), 0);
    chk("mid_ignore_state", 32'(fsm_state), 32'(ST_EMPTY));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_load_seq.md
ROM_LOAD_SEQ -- requirements
Module: rom_load_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning the number of core-reset hold cycles after a load or reset request.
REQ-002 SHALL have parameter TOTAL_BYTES, default 40960 (0xA000), meaning the number of in-range bytes a valid download contains.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1 bit: high while the HPS download is active.
REQ-006 SHALL have port ioctl_wr, input, 1 bit: one-cycle byte write strobe.
REQ-007 SHALL have port ioctl_addr, input, 25 bits: download byte address.
REQ-008 SHALL have port ioctl_dout, input, 8 bits: download byte data.
REQ-009 SHALL have port rst_req, input, 1 bit: user reset request (menu reset or button), level.
REQ-010 SHALL have port cpu_rom_we, output, 1 bit: write strobe for the main CPU ROM (0x0000-0x5FFF).
REQ-011 SHALL have port snd_rom_we, output, 1 bit: write strobe for the sound ROM (0x6000-0x7FFF).
REQ-012 SHALL have port gfx_rom_we, output, 1 bit: write strobe for the graphics ROM (0x8000-0x9FFF).
REQ-013 SHALL have port rom_addr, output, 15 bits: region-local byte address (ioctl_addr minus region base).
REQ-014 SHALL have port rom_data, output, 8 bits: byte to write.
REQ-015 SHALL have port core_reset, output, 1 bit: reset to the game core.
REQ-016 SHALL have port load_ok, output, 1 bit: high when the last download was complete.
REQ-017 SHALL have port load_err, output, 1 bit: high when the last download was short or long.
REQ-018 SHALL have port byte_count, output, 17 bits: in-range write strobes counted in the current/last download.

Function
REQ-019 SHALL implement states EMPTY, LOAD, SETTLE, RUN, FAIL.
REQ-020 SHALL leave EMPTY, SETTLE, RUN or FAIL for LOAD on a rising edge of ioctl_download (registered previous value), clearing byte_count, load_ok and load_err in the same cycle.
REQ-021 SHALL, in LOAD, on ioctl_wr with ioctl_addr < TOTAL_BYTES, assert exactly one of the three ROM write strobes for one cycle, one cycle after the strobe (registered), with rom_addr/rom_data registered alongside.
REQ-022 SHALL ignore ioctl_wr with ioctl_addr >= TOTAL_BYTES (no strobe, no count) and ignore all ioctl_wr outside LOAD.
REQ-023 SHALL increment byte_count on each accepted write, saturating at 0x1FFFF.
REQ-024 SHALL count a write accepted in the same cycle ioctl_download falls.
REQ-025 SHALL, on the falling edge of ioctl_download in LOAD, go to SETTLE with load_ok=1 if the final byte_count equals TOTAL_BYTES, else to FAIL with load_err=1.
REQ-026 SHALL in SETTLE hold core_reset and count SETTLE_CYCLES cycles, then enter RUN; rst_req high restarts the count.
REQ-027 SHALL in RUN move to SETTLE when rst_req is high.
REQ-028 SHALL drive core_reset high in every state except RUN (EMPTY and FAIL hold the core until a valid load).
REQ-029 SHALL give a download rising edge priority over rst_req and over the SETTLE countdown in the same cycle.

Reset
REQ-030 SHALL on RESET enter EMPTY: core_reset=1, all ROM strobes=0, rom_addr=0, rom_data=0, load_ok=0, load_err=0, byte_count=0, settle counter=0, ioctl_download edge register=0.
REQ-031 SHALL abandon a download in progress on RESET; the ROM contents are then treated as invalid (EMPTY).

Structure
REQ-032 SHALL place region bases/sizes, TOTAL_BYTES default and the state enumeration in shared package calipso_rom_pkg.
REQ-033 SHALL use one combinational sub-module rom_region_decode (address -> one-hot region select and local offset).

Verification
REQ-034 SHALL cover full load: 40960 sequential writes 0x0000-0x9FFF -> 24576 cpu, 8192 snd, 8192 gfx strobes; load_ok=1; core_reset falls exactly 16 cycles after download falls.
REQ-035 SHALL cover a short load: writes to 0x0000-0x9FFE only -> FAIL, load_err=1, byte_count=40959, core_reset stays 1.
REQ-036 SHALL cover out-of-range data: a full load plus 100 writes at 0xA000+ -> no extra strobes, byte_count=40960, load_ok=1.
REQ-037 SHALL cover boundary mapping: write at 0x6000, data 0x5A -> snd_rom_we=1, rom_addr=0, rom_data=0x5A one cycle later; write at 0x5FFF -> cpu_rom_we=1, rom_addr=0x5FFF.
REQ-038 SHALL cover a reset request in RUN: rst_req high 3 cycles -> core_reset high and low again 16 cycles after rst_req falls.
REQ-039 SHALL cover RESET mid-download: RESET at byte 1000 -> all outputs at reset values, EMPTY; writes ignored until the next rising ioctl_download.
